// File: rtl/fpga_mem_arbiter_pkg.sv
// Shared definitions for the memory-bridge arbiter: bus widths and FSM state encodings.
package fpga_mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/fpga_mem_arbiter_if.sv
// Requester-side and memory-side signal bundle of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface fpga_mem_arbiter_if
   import fpga_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 7
);
   // Requester side
   logic [NUM_REQ-1:0]        req_wr_en;
   logic [NUM_REQ-1:0]        req_rd_en;
   logic [ADDR_W*NUM_REQ-1:0] req_addr;
   logic [DATA_W*NUM_REQ-1:0] req_wr_data;
   logic [TAG_W*NUM_REQ-1:0]  req_tag;
   logic [NUM_REQ-1:0]        req_ack;
   logic [NUM_REQ-1:0]        req_err;
   logic [DATA_W-1:0]         req_rd_data;
   logic [TAG_W-1:0]          req_tag_resp;
   logic [NUM_REQ-1:0]        req_overflow;

   // Memory-bridge side
   logic                      mem_wr_en;
   logic                      mem_rd_en;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_wr_data;
   logic [TAG_W-1:0]          mem_tag_req;
   logic                      mem_ack;
   logic [DATA_W-1:0]         mem_rd_data;
   logic [TAG_W-1:0]          mem_tag_resp;

   modport slave (
      input  req_wr_en, req_rd_en, req_addr, req_wr_data, req_tag,
      output req_ack, req_err, req_rd_data, req_tag_resp, req_overflow,
      output mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, mem_tag_req,
      input  mem_ack, mem_rd_data, mem_tag_resp
   );

   modport master (
      output req_wr_en, req_rd_en, req_addr, req_wr_data, req_tag,
      input  req_ack, req_err, req_rd_data, req_tag_resp, req_overflow,
      input  mem_wr_en, mem_rd_en, mem_addr, mem_wr_data, mem_tag_req,
      output mem_ack, mem_rd_data, mem_tag_resp
   );

endinterface

// File: rtl/fpga_mem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     valid,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant_oh,
   output logic [IDX_W-1:0] grant_idx
);

   logic             found;
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Scan candidates ptr, ptr+1, ... (mod N) and keep the first valid one.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write so no latch is inferred.
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
         cand = sum[IDX_W-1:0];
         if (!found && valid[cand]) begin
            found          = 1'b1;
            grant_oh[cand] = 1'b1;
            grant_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/fpga_mem_arbiter.sv
// Shares one memory-bridge port among NUM_REQ requesters: latches pulsed
// requests into per-port slots, issues one at a time round-robin, routes the
// completion back to its owner and forces an error completion on timeout.
module fpga_mem_arbiter
   import fpga_mem_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TAG_W       = 7,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic               clk,
   input logic               rst,
   fpga_mem_arbiter_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   // Pending slots
   logic [NUM_REQ-1:0]             valid_q, valid_d;
   logic [NUM_REQ-1:0]             is_wr_q, is_wr_d;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_q, addr_d;
   logic [NUM_REQ-1:0][DATA_W-1:0] data_q, data_d;
   logic [NUM_REQ-1:0][TAG_W-1:0]  tag_q, tag_d;
   logic [NUM_REQ-1:0]             overflow_q, overflow_d;

   // Transaction control
   state_t                         state_q, state_d;
   logic [IDX_W-1:0]               grant_q, grant_d;
   logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           err_q, err_d;
   logic [DATA_W-1:0]              resp_data_q, resp_data_d;
   logic [TAG_W-1:0]               resp_tag_q, resp_tag_d;

   // Downstream registers
   logic                           mem_wr_en_q, mem_wr_en_d;
   logic                           mem_rd_en_q, mem_rd_en_d;
   logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]              mem_data_q, mem_data_d;
   logic [TAG_W-1:0]               mem_tag_q, mem_tag_d;

   logic [NUM_REQ-1:0]             arb_oh;
   logic [IDX_W-1:0]               arb_idx;
   logic [NUM_REQ-1:0]             ack_oh;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
      .valid     (valid_q),
      .ptr       (rr_ptr_q),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx)
   );

   // Slot capture: clear the issued slot first so a same-cycle request refills it.
   always_comb begin
      valid_d    = valid_q;
      is_wr_d    = is_wr_q;
      addr_d     = addr_q;
      data_d     = data_q;
      tag_d      = tag_q;
      overflow_d = overflow_q;
      if (state_q == ST_ISSUE) valid_d[grant_q] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (bus.req_wr_en[i] || bus.req_rd_en[i]) begin
            if (valid_d[i]) begin
               overflow_d[i] = 1'b1;
            end else begin
               valid_d[i] = 1'b1;
               is_wr_d[i] = bus.req_wr_en[i];
               addr_d[i]  = bus.req_addr[ADDR_W*i +: ADDR_W];
               data_d[i]  = bus.req_wr_data[DATA_W*i +: DATA_W];
               tag_d[i]   = bus.req_tag[TAG_W*i +: TAG_W];
            end
         end
      end
   end

   // Transaction FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      resp_data_d = resp_data_q;
      resp_tag_d  = resp_tag_q;
      mem_wr_en_d = 1'b0;
      mem_rd_en_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_tag_d   = mem_tag_q;
      case (state_q)
         ST_IDLE: begin
            if (|arb_oh) begin
               grant_d     = arb_idx;
               mem_wr_en_d = is_wr_q[arb_idx];
               mem_rd_en_d = !is_wr_q[arb_idx];
               mem_addr_d  = addr_q[arb_idx];
               mem_data_d  = data_q[arb_idx];
               mem_tag_d   = tag_q[arb_idx];
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            rr_ptr_d = (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + IDX_W'(1);
            cnt_d    = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.mem_ack) begin
               resp_data_d = bus.mem_rd_data;
               resp_tag_d  = bus.mem_tag_resp;
               err_d       = 1'b0;
               state_d     = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC-1)) begin
               resp_data_d = '0;
               resp_tag_d  = mem_tag_q;
               err_d       = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and output state, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         valid_q     <= '0;
         overflow_q  <= '0;
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         resp_data_q <= '0;
         resp_tag_q  <= '0;
         mem_wr_en_q <= 1'b0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
         mem_tag_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         overflow_q  <= overflow_d;
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         resp_data_q <= resp_data_d;
         resp_tag_q  <= resp_tag_d;
         mem_wr_en_q <= mem_wr_en_d;
         mem_rd_en_q <= mem_rd_en_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_tag_q   <= mem_tag_d;
      end
   end

   // Slot payload storage.
   always_ff @(posedge clk) begin
      // NOTE: payload is only ever read while its valid bit is set, so it needs no reset.
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
   end

   // One-hot owner of the current transaction.
   always_comb begin
      ack_oh          = '0;
      ack_oh[grant_q] = 1'b1;
   end

   assign bus.req_ack      = (state_q == ST_RESP) ? ack_oh : '0;
   assign bus.req_err      = err_q ? bus.req_ack : '0;
   assign bus.req_rd_data  = resp_data_q;
   assign bus.req_tag_resp = resp_tag_q;
   assign bus.req_overflow = overflow_q;
   assign bus.mem_wr_en    = mem_wr_en_q;
   assign bus.mem_rd_en    = mem_rd_en_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wr_data  = mem_data_q;
   assign bus.mem_tag_req  = mem_tag_q;

endmodule
